// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the multi-cycle multiply sequencer.
// State and accumulate-mode encodings live here so core and top agree.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    MultIdle = 2'b00,
    MultBusy = 2'b01,
    MultAcc  = 2'b10,
    MultDone = 2'b11
  } mult_state_e;

  typedef enum logic [1:0] {
    AccNone = 2'b00,
    AccAdd  = 2'b01,
    AccSub  = 2'b10
  } acc_op_e;

  localparam logic [63:0] DoubleZero = 64'd0;

  // The reserved code 2'b11 behaves as a plain multiply.
  function automatic acc_op_e decode_acc(input logic [1:0] code);
    case (code)
      2'b01:   return AccAdd;
      2'b10:   return AccSub;
      default: return AccNone;
    endcase
  endfunction

endpackage

// File: rtl/mult_seq_core.sv
// Combinational 32x32 -> 64 multiplier: magnitudes are multiplied as
// unsigned shift-add partial products and the sign is applied afterwards.
module mult_core
  import mult_seq_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        signed_op,
  output logic [63:0] product
);

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] pp [32];
  logic [63:0] mag_sum;

  assign a_neg = signed_op & a[31];
  assign b_neg = signed_op & b[31];
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign a_mag = a_neg ? (~a + 32'd1) : a;
  assign b_mag = b_neg ? (~b + 32'd1) : b;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_pp
      assign pp[gi] = b_mag[gi] ? ({32'd0, a_mag} << gi) : DoubleZero;
    end
  endgenerate

  always_comb begin
    mag_sum = DoubleZero;
    for (int i = 0; i < 32; i++) begin
      mag_sum = mag_sum + pp[i];
    end
  end

  assign product = (a_neg ^ b_neg) ? (~mag_sum + 64'd1) : mag_sum;

endmodule

// File: rtl/mult_seq.sv
// Multi-cycle sequencer for the EX-stage multiplier: latches operands at
// start, stalls EX for the multiply (and optional HI/LO accumulate), then pulses ready.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [1:0]  acc_op_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic [63:0] hilo_i,
  input  logic        annul_i,
  output logic        stallreq_o,
  output logic        ready_o,
  output logic [63:0] result_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(LATENCY - 1);

  mult_state_e      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      op1_reg;
  logic [31:0]      op2_reg;
  logic             signed_reg;
  acc_op_e          acc_mode_reg;
  logic [63:0]      hilo_reg;
  logic [63:0]      prod_reg;
  logic [63:0]      acc_reg;
  logic [63:0]      product;

  mult_core u_core (
    .a         (op1_reg),
    .b         (op2_reg),
    .signed_op (signed_reg),
    .product   (product)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= MultIdle;
      cnt_reg      <= '0;
      op1_reg      <= '0;
      op2_reg      <= '0;
      signed_reg   <= 1'b0;
      acc_mode_reg <= AccNone;
      hilo_reg     <= DoubleZero;
      prod_reg     <= DoubleZero;
      acc_reg      <= DoubleZero;
    end else if (annul_i) begin
      state_reg    <= MultIdle;
      cnt_reg      <= '0;
      op1_reg      <= '0;
      op2_reg      <= '0;
      signed_reg   <= 1'b0;
      acc_mode_reg <= AccNone;
      hilo_reg     <= DoubleZero;
    end else begin
      case (state_reg)
        MultIdle: begin
          if (start_i) begin
            op1_reg      <= opdata1_i;
            op2_reg      <= opdata2_i;
            signed_reg   <= signed_i;
            acc_mode_reg <= decode_acc(acc_op_i);
            hilo_reg     <= hilo_i;
            cnt_reg      <= '0;
            state_reg    <= MultBusy;
          end
        end
        MultBusy: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CntLast) begin
            prod_reg  <= product;
            cnt_reg   <= '0;
            state_reg <= (acc_mode_reg == AccNone) ? MultDone : MultAcc;
          end
        end
        MultAcc: begin
          acc_reg   <= (acc_mode_reg == AccSub) ? (hilo_reg - prod_reg)
                                                : (hilo_reg + prod_reg);
          state_reg <= MultDone;
        end
        default: begin
          state_reg <= MultIdle;
        end
      endcase
    end
  end

  // Stall and ready react combinationally so annul and the start cycle act at once.
  assign stallreq_o = rst & ~annul_i &
                      (((state_reg == MultIdle) & start_i) |
                       (state_reg == MultBusy) |
                       (state_reg == MultAcc));

  assign ready_o  = rst & ~annul_i & (state_reg == MultDone);
  assign result_o = ready_o ? ((acc_mode_reg == AccNone) ? prod_reg : acc_reg)
                            : DoubleZero;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_mult_seq;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [1:0]  acc_op_i = 2'b00;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [63:0] hilo_i = '0;
  logic        annul_i = 1'b0;
  logic        stallreq_o;
  logic        ready_o;
  logic [63:0] result_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_seq #(.LATENCY(LAT), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .acc_op_i   (acc_op_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .hilo_i     (hilo_i),
    .annul_i    (annul_i),
    .stallreq_o (stallreq_o),
    .ready_o    (ready_o),
    .result_o   (result_o)
  );

  function automatic logic [63:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn, input logic [1:0] acc,
                                            input logic [63:0] hilo);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end
    if (acc == 2'b01)      return hilo + p;
    else if (acc == 2'b10) return hilo - p;
    else                   return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One full operation; inputs are scrambled after the start cycle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [1:0] acc, input logic [63:0] hilo);
    logic [63:0] exp_res;
    int          lat;
    logic [63:0] got;
    exp_res = ref_model(a, b, sgn, acc, hilo);
    lat = (acc == 2'b01 || acc == 2'b10) ? LAT + 2 : LAT + 1;
    got = '0;
    @(posedge clk); #1;
    start_i = 1'b1; annul_i = 1'b0; signed_i = sgn; acc_op_i = acc;
    opdata1_i = a; opdata2_i = b; hilo_i = hilo;
    @(negedge clk);
    check({tag, "_stall_start"}, 64'(stallreq_o), 64'd1);
    check({tag, "_ready_start"}, 64'(ready_o), 64'd0);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      opdata1_i = $urandom; opdata2_i = $urandom;
      hilo_i = {$urandom, $urandom};
      signed_i = 1'($urandom); acc_op_i = 2'($urandom);
      @(negedge clk);
      if (k < lat) begin
        check({tag, "_stall_busy"}, 64'(stallreq_o), 64'd1);
        check({tag, "_ready_busy"}, 64'(ready_o), 64'd0);
        check({tag, "_result_busy"}, result_o, 64'd0);
      end else begin
        got = result_o;
        check({tag, "_ready_done"}, 64'(ready_o), 64'd1);
        check({tag, "_stall_done"}, 64'(stallreq_o), 64'd0);
        check({tag, "_result"}, result_o, exp_res);
      end
    end
    $display("op %s a=%h b=%h signed=%0d acc=%0d hilo=%h expected=%h got=%h",
             tag, a, b, sgn, acc, hilo, exp_res, got);
  endtask

  initial begin
    #3;
    check("reset_stall", 64'(stallreq_o), 64'd0);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    @(posedge clk); #2;
    rst = 1'b1;

    run_op("multu_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2'b00, 64'd0);
    run_op("mult_neg", 32'hFFFFFFFF, 32'h00000002, 1'b1, 2'b00, 64'd0);
    run_op("mult_min", 32'h80000000, 32'h80000000, 1'b1, 2'b00, 64'd0);
    run_op("madd", 32'd3, 32'd4, 1'b1, 2'b01, 64'd1);
    run_op("msubu_wrap", 32'd1, 32'd1, 1'b0, 2'b10, 64'd0);
    run_op("acc_reserved", 32'd9, 32'hFFFFFFF0, 1'b1, 2'b11, 64'h1234);

    // Annul in the second multiply cycle.
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; acc_op_i = 2'b00;
    opdata1_i = 32'd5; opdata2_i = 32'd6; hilo_i = '0; annul_i = 1'b0;
    @(negedge clk);
    check("annul_stall_start", 64'(stallreq_o), 64'd1);
    @(posedge clk); #1; start_i = 1'b0;
    @(negedge clk);
    check("annul_stall_mul1", 64'(stallreq_o), 64'd1);
    @(posedge clk); #1; annul_i = 1'b1;
    @(negedge clk);
    check("annul_stall", 64'(stallreq_o), 64'd0);
    check("annul_ready", 64'(ready_o), 64'd0);
    @(posedge clk); #1; annul_i = 1'b0;
    @(negedge clk);
    check("annul_idle_stall", 64'(stallreq_o), 64'd0);
    check("annul_idle_ready", 64'(ready_o), 64'd0);
    run_op("after_annul", 32'd7, 32'd8, 1'b0, 2'b00, 64'd0);

    // Asynchronous reset in the middle of a multiply.
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; acc_op_i = 2'b01;
    opdata1_i = 32'd9; opdata2_i = 32'd9; hilo_i = 64'd5;
    @(negedge clk);
    @(posedge clk); #1; start_i = 1'b0;
    @(negedge clk);
    check("rst_pre_stall", 64'(stallreq_o), 64'd1);
    #2; rst = 1'b0; #1;
    check("rst_async_stall", 64'(stallreq_o), 64'd0);
    check("rst_async_ready", 64'(ready_o), 64'd0);
    check("rst_async_result", result_o, 64'd0);
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #1; start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk);
    check("start_annul_stall", 64'(stallreq_o), 64'd0);
    check("start_annul_ready", 64'(ready_o), 64'd0);
    for (int k = 0; k < LAT + 3; k++) begin
      @(posedge clk); #1; start_i = 1'b0; annul_i = 1'b0;
      @(negedge clk);
      check("start_annul_idle_stall", 64'(stallreq_o), 64'd0);
      check("start_annul_idle_ready", 64'(ready_o), 64'd0);
    end

    for (int n = 0; n < 24; n++) begin
      run_op("random", $urandom, $urandom, 1'($urandom), 2'($urandom),
             {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
